// File: rtl/classifier_argmax_stream_if.sv
// Beat / result bundle for classifier_argmax_stream.
// bias_in is present only when CLS_BIAS_EN is defined.
interface classifier_argmax_stream_if #(
  parameter int unsigned X_W        = 4,
  parameter int unsigned W_W        = 8,
  parameter int unsigned ACC_W      = 20,
  parameter int unsigned CLASS_BITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [X_W-1:0]        x_in;
  logic [W_W-1:0]        w_in;
  logic                  in_last;
`ifdef CLS_BIAS_EN
  logic [ACC_W-1:0]      bias_in;
`endif
  logic [ACC_W-1:0]      acc_out;
  logic [CLASS_BITS-1:0] class_idx;
  logic                  res_valid;
  logic [CLASS_BITS-1:0] res_class;
  logic [ACC_W-1:0]      res_score;
  logic                  res_sat;

  modport master (
`ifdef CLS_BIAS_EN
    output bias_in,
`endif
    output in_valid,
    output x_in,
    output w_in,
    output in_last,
    input  in_ready,
    input  acc_out,
    input  class_idx,
    input  res_valid,
    input  res_class,
    input  res_score,
    input  res_sat
  );

  modport slave (
`ifdef CLS_BIAS_EN
    input  bias_in,
`endif
    input  in_valid,
    input  x_in,
    input  w_in,
    input  in_last,
    output in_ready,
    output acc_out,
    output class_idx,
    output res_valid,
    output res_class,
    output res_score,
    output res_sat
  );
endinterface

// File: rtl/classifier_argmax_stream.sv
// Streaming saturating MAC with per-frame argmax; one {class, score} result per frame.
// Optional per-class bias added at compare time when CLS_BIAS_EN is defined.
module classifier_argmax_stream #(
  parameter int unsigned X_W        = 4,
  parameter int unsigned W_W        = 8,
  parameter int unsigned ACC_W      = 20,
  parameter int unsigned N_CLASSES  = 8,
  parameter int unsigned CLASS_BITS = 3
) (
  input logic                     clk,
  input logic                     rst,
  classifier_argmax_stream_if.slave bus
);

  localparam int unsigned PROD_W = X_W + W_W;
  localparam logic [CLASS_BITS-1:0] LastClass = CLASS_BITS'(N_CLASSES - 1);
  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {StAcc, StCmp, StDone} state_e;

  // Returns {overflow, clamped sum} of two ACC_W-bit two's-complement values.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      return {1'b1, (sum[ACC_W] ? AccMin : AccMax)};
    end
    return {1'b0, sum[ACC_W-1:0]};
  endfunction

  state_e                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CLASS_BITS-1:0] class_q, class_d;
  logic [ACC_W-1:0]      max_q, max_d;
  logic [CLASS_BITS-1:0] max_idx_q, max_idx_d;
  logic                  sat_q, sat_d;
  logic                  res_valid_q, res_valid_d;
  logic [CLASS_BITS-1:0] res_class_q, res_class_d;
  logic [ACC_W-1:0]      res_score_q, res_score_d;
  logic                  res_sat_q, res_sat_d;

  logic                  in_ready;
  logic                  beat;
  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]      prod_ext;
  logic [ACC_W:0]        mac_res;
  logic [ACC_W:0]        score_res;
  logic [ACC_W-1:0]      score;
  logic                  score_sat;
  logic                  take_max;

  assign beat     = bus.in_valid & in_ready;
  assign prod     = $signed(bus.x_in) * $signed(bus.w_in);
  assign prod_ext = ACC_W'(prod);
  assign mac_res  = sat_add(acc_q, prod_ext);

`ifdef CLS_BIAS_EN
  assign score_res = sat_add(acc_q, bus.bias_in);
`else
  assign score_res = {1'b0, acc_q};
`endif
  assign score     = score_res[ACC_W-1:0];
  assign score_sat = score_res[ACC_W];
  // Strict compare: on a tie the earlier (lower) class index is kept.
  assign take_max  = (class_q == '0) || ($signed(score) > $signed(max_q));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAcc;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAcc:   if (beat && bus.in_last) state_d = StCmp;
      StCmp:   state_d = (class_q == LastClass) ? StDone : StAcc;
      StDone:  state_d = StAcc;
      default: state_d = StAcc;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StAcc:   in_ready = 1'b1;
      StCmp:   in_ready = 1'b0;
      StDone:  in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    acc_d       = acc_q;
    class_d     = class_q;
    max_d       = max_q;
    max_idx_d   = max_idx_q;
    sat_d       = sat_q;
    res_valid_d = 1'b0;
    res_class_d = res_class_q;
    res_score_d = res_score_q;
    res_sat_d   = res_sat_q;
    unique case (state_q)
      StAcc: begin
        if (beat) begin
          acc_d = mac_res[ACC_W-1:0];
          sat_d = sat_q | mac_res[ACC_W];
        end
      end
      StCmp: begin
        if (take_max) begin
          max_d     = score;
          max_idx_d = class_q;
        end
        acc_d = '0;
        sat_d = sat_q | score_sat;
        if (class_q != LastClass) class_d = class_q + 1'b1;
      end
      StDone: begin
        res_valid_d = 1'b1;
        res_class_d = max_idx_q;
        res_score_d = max_q;
        res_sat_d   = sat_q;
        class_d     = '0;
        sat_d       = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      class_q     <= '0;
      max_q       <= '0;
      max_idx_q   <= '0;
      sat_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_score_q <= '0;
      res_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      class_q     <= class_d;
      max_q       <= max_d;
      max_idx_q   <= max_idx_d;
      sat_q       <= sat_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      res_score_q <= res_score_d;
      res_sat_q   <= res_sat_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.acc_out   = acc_q;
  assign bus.class_idx = class_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_class = res_class_q;
  assign bus.res_score = res_score_q;
  assign bus.res_sat   = res_sat_q;

endmodule

// File: tb/tb_classifier_argmax_stream.sv
// Directed, table-driven bench for classifier_argmax_stream (ACC_W=12, 8 classes).
// Frame vectors carry hand-computed argmax results; CLS_BIAS_EN adds the bias frame.
module tb_classifier_argmax_stream;

  localparam int unsigned X_W   = 4;
  localparam int unsigned W_W   = 8;
  localparam int unsigned ACC_W = 12;
  localparam int unsigned NCLS  = 8;
  localparam int unsigned CB    = 3;

  typedef struct packed {
    logic [7:0][3:0] x;
    logic [7:0][7:0] w;
    logic [7:0][7:0] nb;
    logic            gaps;
    logic            bias_mode;
    logic [2:0]      e_class;
    logic [11:0]     e_score;
    logic            e_sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  classifier_argmax_stream_if #(
    .X_W(X_W), .W_W(W_W), .ACC_W(ACC_W), .CLASS_BITS(CB)
  ) bus ();

  classifier_argmax_stream #(
    .X_W(X_W), .W_W(W_W), .ACC_W(ACC_W), .N_CLASSES(NCLS), .CLASS_BITS(CB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the beat until accepted; returns 1 ns after the accepting edge.
  task automatic send_beat(input logic [3:0] x, input logic [7:0] w, input logic last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    bus.w_in     = w;
    bus.in_last  = last;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("beat_accept_timeout", 32'(n), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    for (int c = 0; c < int'(NCLS); c++) begin
`ifdef CLS_BIAS_EN
      bus.bias_in = v.bias_mode ? 12'(c) : 12'd0;
`endif
      for (int b = 0; b < int'(v.nb[c]); b++) begin
        if (v.gaps) begin
          bus.in_valid = 1'b0;
          repeat (1 + (b % 2)) tick();
        end
        send_beat(v.x[c], v.w[c], b == int'(v.nb[c]) - 1);
      end
      if (c < int'(NCLS) - 1) begin
        tick();  // compare cycle
      end
    end
    check({tag, "_ready_cmp"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_valid_cmp"}, 32'(bus.res_valid), 32'd0);
    tick();
    check({tag, "_valid_done"}, 32'(bus.res_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_class"}, 32'(bus.res_class), 32'(v.e_class));
    check({tag, "_score"}, 32'(bus.res_score), 32'(v.e_score));
    check({tag, "_sat"}, 32'(bus.res_sat), 32'(v.e_sat));
    tick();
    check({tag, "_valid_pulse_end"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_class_hold"}, 32'(bus.res_class), 32'(v.e_class));
  endtask

  function automatic vec_t blank_vec();
    vec_t v;
    v = '0;
    return v;
  endfunction

  initial begin
    automatic vec_t v;
    automatic int t4w[8] = '{5, 3, 9, 10, 11, 12, 13, 14};

    // T1: x=1, w=3*class -> class 7, score 21
    v = blank_vec();
    for (int i = 0; i < 8; i++) begin v.x[i] = 4'd1; v.w[i] = 8'(3 * i); v.nb[i] = 8'd1; end
    v.e_class = 3'd7; v.e_score = 12'd21;
    vecs.push_back(v);
    // T2: all ties -> lowest class wins
    v = blank_vec();
    for (int i = 0; i < 8; i++) begin v.x[i] = 4'd2; v.w[i] = 8'd5; v.nb[i] = 8'd1; end
    v.e_class = 3'd0; v.e_score = 12'd10;
    vecs.push_back(v);
    // T3: class 3 saturates positive (40 * 889 > 2047)
    v = blank_vec();
    for (int i = 0; i < 8; i++) begin v.x[i] = 4'd1; v.w[i] = 8'd1; v.nb[i] = 8'd1; end
    v.x[3] = 4'd7; v.w[3] = 8'd127; v.nb[3] = 8'd40;
    v.e_class = 3'd3; v.e_score = 12'd2047; v.e_sat = 1'b1;
    vecs.push_back(v);
    // Clean frame after saturation: sat must be cleared
    v = blank_vec();
    for (int i = 0; i < 8; i++) begin v.x[i] = 4'd1; v.w[i] = 8'(i); v.nb[i] = 8'd1; end
    v.e_class = 3'd7; v.e_score = 12'd7;
    vecs.push_back(v);
    // T4: all negative, best is -3 at class 1
    v = blank_vec();
    for (int i = 0; i < 8; i++) begin v.x[i] = 4'hF; v.w[i] = 8'(t4w[i]); v.nb[i] = 8'd1; end
    v.e_class = 3'd1; v.e_score = 12'hFFD;
    vecs.push_back(v);
    // 3 beats/class, score 6*(7-class) -> class 0, 42; then identical with valid gaps
    v = blank_vec();
    for (int i = 0; i < 8; i++) begin v.x[i] = 4'd2; v.w[i] = 8'(7 - i); v.nb[i] = 8'd3; end
    v.e_class = 3'd0; v.e_score = 12'd42;
    vecs.push_back(v);
    v.gaps = 1'b1;
    vecs.push_back(v);
`ifdef CLS_BIAS_EN
    // T6: equal accs of 10, bias = class -> class 7, 17
    v = blank_vec();
    for (int i = 0; i < 8; i++) begin v.x[i] = 4'd2; v.w[i] = 8'd5; v.nb[i] = 8'd1; end
    v.bias_mode = 1'b1; v.e_class = 3'd7; v.e_score = 12'd17;
    vecs.push_back(v);
`endif

    bus.in_valid = 1'b0;
    bus.x_in     = '0;
    bus.w_in     = '0;
    bus.in_last  = 1'b0;
`ifdef CLS_BIAS_EN
    bus.bias_in  = '0;
`endif
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_acc", 32'(bus.acc_out), 32'd0);
    check("rst_class_idx", 32'(bus.class_idx), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_class", 32'(bus.res_class), 32'd0);
    check("rst_res_score", 32'(bus.res_score), 32'd0);
    check("rst_res_sat", 32'(bus.res_sat), 32'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      run_frame(vecs[k], $sformatf("vec%0d", k));
    end

    // Accumulator holds without beats; a beat offered during compare waits.
`ifdef CLS_BIAS_EN
    bus.bias_in = '0;
`endif
    send_beat(4'd3, 8'd4, 1'b0);
    tick();
    tick();
    check("hold_acc", 32'(bus.acc_out), 32'd12);
    check("hold_class_idx", 32'(bus.class_idx), 32'd0);
    send_beat(4'd1, 8'd1, 1'b1);
    bus.in_valid = 1'b1;
    bus.x_in     = 4'd7;
    bus.w_in     = 8'd7;
    bus.in_last  = 1'b0;
    check("stall_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("stall_acc_clear", 32'(bus.acc_out), 32'd0);
    check("stall_class_idx", 32'(bus.class_idx), 32'd1);
    tick();
    check("stall_beat_once", 32'(bus.acc_out), 32'd49);
    bus.in_valid = 1'b0;
    send_beat(4'd0, 8'd0, 1'b1);
    tick();
    send_beat(4'd1, 8'd1, 1'b1);
    tick();
    send_beat(4'd1, 8'd1, 1'b1);
    tick();
    send_beat(4'd2, 8'd3, 1'b0);
    check("mid_class_idx", 32'(bus.class_idx), 32'd4);
    check("mid_acc", 32'(bus.acc_out), 32'd6);

    // Mid-frame reset during class 4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_acc", 32'(bus.acc_out), 32'd0);
    check("mrst_class_idx", 32'(bus.class_idx), 32'd0);
    check("mrst_res_valid", 32'(bus.res_valid), 32'd0);
    check("mrst_res_class", 32'(bus.res_class), 32'd0);
    check("mrst_res_score", 32'(bus.res_score), 32'd0);
    check("mrst_res_sat", 32'(bus.res_sat), 32'd0);
    check("mrst_ready", 32'(bus.in_ready), 32'd1);
    run_frame(vecs[0], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
